uart_frame_tx: RTL and testbench
================================

// Module: uart_frame_tx
// PURPOSE
//  Serialises one variable-length frame (1..DATA_MAX_LEN data bits) onto the UART tx line.
//  Sits directly downstream of the main-memory bridge and drives its tx pin.
//  Carries MEMCMD bytes and address/data words (9-bit frames) to the external memory host.
//  Frame format: start bit, optional parity bit, stop bit(s).
// PARAMETERS
//  CLK          50    core clock in MHz
//  BAUD_RATE    9600  line rate, bits/s
//  DATA_MAX_LEN 9     width of data port, max bits per frame
//  PARITY       0     0 none, 1 even, 2 odd
//  STOP_BITS    1     stop bits per frame (1 or 2)
// PORTS
//  clk    in   1             core clock; all logic on posedge
//  res    in   1             synchronous active-high reset
//  send   in   1             request to transmit; sampled only while ready=1
//  len    in   32            bits in frame; 0 or >DATA_MAX_LEN clamps to DATA_MAX_LEN
//  data   in   DATA_MAX_LEN  payload; bit 0 is sent first
//  tx     out  1             serial line, idle high
//  ready  out  1             1 = idle, will accept send this cycle
// BEHAVIOUR
//  Reset (res=1 at posedge): tx=1, ready=1, state IDLE, counters 0.
//   Reset mid-frame aborts the frame; tx=1 after that edge and no partial bits resume.
//  DIV = CLK*1_000_000/BAUD_RATE, integer floor, min 1; every line bit holds exactly DIV cycles.
//  Accept: posedge with ready&send. On that edge: latch data and clamped len; ready<=0; state START.
//   tx<=0 on the same edge, so latency is 1 cycle from accept to the start-bit edge.
//  send while ready=0 is ignored and not queued; data/len changes after accept have no effect.
//  States and transitions:
//   IDLE -> START on accept.
//   START (DIV cycles) -> DATA.
//   DATA: shift latched bits LSB first, 1 bit per DIV cycles, len bits total.
//   DATA -> PARITY if PARITY!=0, else -> STOP.
//   PARITY (DIV cycles): even parity = XOR of the len sent bits; odd = inverse. -> STOP.
//   STOP: tx=1 for STOP_BITS*DIV cycles -> IDLE.
//  Bits above len in latched data are never sent and never enter parity.
//  ready<=1 on the edge that ends the last stop period (tx stays 1).
//   If send=1 in the first ready cycle, the next start bit begins on the following edge.
//   A line-idle gap of 0 cycles beyond the stop bits is legal.
//  Baud counter: 0..DIV-1. Wrap at DIV-1 produces a one-cycle bit_tick that advances the bit.
//   The counter resets to 0 on accept, so every frame's bit timing is aligned to accept.
//  Bit counter width is $clog2(DATA_MAX_LEN+1) and saturates; no wrap-around into payload.
//  Simultaneous res and send: res wins, frame not accepted.
// STRUCTURE
//  Shared package uart_pkg:
//   - typedef enum UartTxState {IDLE, START, DATA, PARITY, STOP}
//   - function baud_div(CLK, BAUD_RATE) returning DIV
//   - localparam encodings for PARITY modes
//   The receive side reuses the same package.
//  One sub-module: uart_baud_gen. It holds the DIV counter, with inputs clk, res, clear and output tick.
//  The FSM and shift register live in uart_frame_tx.
// TESTING (bench params CLK=1, BAUD_RATE=250000 -> DIV=4 unless stated)
//  1. Reset: hold res 3 cycles -> tx=1, ready=1. Pulse send during res -> no start bit.
//  2. len=8, data=9'h0A5, PARITY=0, accept at cycle T:
//     tx=0 over [T+1,T+4], then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then 4 cycles of 1.
//     ready=1 at T+41.
//  3. len=9, data=9'h1FF, PARITY=1: 9 ones then parity bit 1.
//     Same frame with PARITY=2 -> parity bit 0. Frame length is 48 cycles.
//  4. len=0 and len=20 both send 9 bits. data=9'h155, len=4 -> bits 1,0,1,0 only.
//     No parity contribution from bits 4..8.
//  5. Hold send=1 continuously for 3 frames -> stop bit of each is followed immediately by the next start bit.
//     send pulses while busy produce no extra frame.
//  6. Assert res in the DATA state of a frame -> tx=1 and ready=1 one edge later.
//     A fresh send then produces a complete, correct frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: line-state encoding, parity mode codes and baud divisor helper.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} UartTxState;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // Core clock is given in MHz; result is floored and never below one cycle per bit.
  function automatic int baud_div(input int clk_mhz, input int baud_rate);
    longint d;
    d = longint'(clk_mhz) * 64'd1_000_000 / longint'(baud_rate);
    return (d < 1) ? 1 : int'(d);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter 0..DIV-1; tick is high for the last cycle of each bit period.
// clear restarts the period so a new frame is timed from its accept edge.
module uart_baud_gen #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic res,
  input  logic clear,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] cnt;

  assign tick = (cnt == W'(DIV - 1));

  always_ff @(posedge clk) begin
    if (res || clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/uart_frame_tx.sv
// Serialises one start/data/parity/stop frame per accepted send; tx changes 1 cycle after accept.
// ready is low for the whole frame; send while busy is dropped, never queued.
module uart_frame_tx #(
  parameter int CLK          = 50,
  parameter int BAUD_RATE    = 9600,
  parameter int DATA_MAX_LEN = 9,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                    clk,
  input  logic                    res,
  input  logic                    send,
  input  logic [31:0]             len,
  input  logic [DATA_MAX_LEN-1:0] data,
  output logic                    tx,
  output logic                    ready
);

  import uart_pkg::*;

  localparam int DIV = baud_div(CLK, BAUD_RATE);
  localparam int BW  = $clog2(DATA_MAX_LEN + 1);

  UartTxState              state;
  logic [DATA_MAX_LEN-1:0] shreg;
  logic [DATA_MAX_LEN-1:0] shreg_nxt;
  logic [BW-1:0]           bits_left;
  logic [BW-1:0]           len_clamped;
  logic                    par;
  logic                    par_nxt;
  logic                    stop_cnt;
  logic                    tick;
  logic                    accept;

  assign accept      = ready & send;
  assign len_clamped = (len == 32'd0 || len > 32'(DATA_MAX_LEN)) ? BW'(DATA_MAX_LEN) : BW'(len);
  assign shreg_nxt   = shreg >> 1;
  assign par_nxt     = par ^ shreg[0];

  uart_baud_gen #(.DIV(DIV)) u_baud (
    .clk  (clk),
    .res  (res),
    .clear(accept),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (res) begin
      state     <= IDLE;
      tx        <= 1'b1;
      ready     <= 1'b1;
      shreg     <= '0;
      bits_left <= '0;
      par       <= 1'b0;
      stop_cnt  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            shreg     <= data;
            bits_left <= len_clamped;
            par       <= 1'b0;
            stop_cnt  <= 1'b0;
            tx        <= 1'b0;
            ready     <= 1'b0;
            state     <= START;
          end
        end
        START: begin
          if (tick) begin
            tx    <= shreg[0];
            state <= DATA;
          end
        end
        DATA: begin
          // parity accumulates only bits that actually go on the line
          if (tick) begin
            shreg <= shreg_nxt;
            par   <= par_nxt;
            if (bits_left > BW'(1)) begin
              bits_left <= bits_left - BW'(1);
              tx        <= shreg_nxt[0];
            end else begin
              bits_left <= '0;
              if (PARITY != PARITY_NONE) begin
                tx    <= (PARITY == PARITY_ODD) ? ~par_nxt : par_nxt;
                state <= uart_pkg::PARITY;
              end else begin
                tx    <= 1'b1;
                state <= STOP;
              end
            end
          end
        end
        uart_pkg::PARITY: begin
          if (tick) begin
            tx    <= 1'b1;
            state <= STOP;
          end
        end
        STOP: begin
          if (tick) begin
            if (stop_cnt == 1'(STOP_BITS - 1)) begin
              stop_cnt <= 1'b0;
              ready    <= 1'b1;
              state    <= IDLE;
            end else begin
              stop_cnt <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_tx.sv
// Directed bench for uart_frame_tx at DIV=4: four instances share stimulus
// (no parity, even, odd, and no parity with two stop bits); each line bit is expected for exactly 4 cycles.
module tb_uart_frame_tx;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        res;
  logic        send;
  logic [31:0] len;
  logic [8:0]  data;
  logic [3:0]  tx_v;
  logic [3:0]  rdy_v;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_bits [4];
  int          exp_n    [4];

  always #5 clk = ~clk;

  uart_frame_tx #(.CLK(1), .BAUD_RATE(250000), .DATA_MAX_LEN(9), .PARITY(0), .STOP_BITS(1)) dut_a (
    .clk(clk), .res(res), .send(send), .len(len), .data(data), .tx(tx_v[0]), .ready(rdy_v[0]));
  uart_frame_tx #(.CLK(1), .BAUD_RATE(250000), .DATA_MAX_LEN(9), .PARITY(1), .STOP_BITS(1)) dut_b (
    .clk(clk), .res(res), .send(send), .len(len), .data(data), .tx(tx_v[1]), .ready(rdy_v[1]));
  uart_frame_tx #(.CLK(1), .BAUD_RATE(250000), .DATA_MAX_LEN(9), .PARITY(2), .STOP_BITS(1)) dut_c (
    .clk(clk), .res(res), .send(send), .len(len), .data(data), .tx(tx_v[2]), .ready(rdy_v[2]));
  uart_frame_tx #(.CLK(1), .BAUD_RATE(250000), .DATA_MAX_LEN(9), .PARITY(0), .STOP_BITS(2)) dut_d (
    .clk(clk), .res(res), .send(send), .len(len), .data(data), .tx(tx_v[3]), .ready(rdy_v[3]));

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (rdy_v !== 4'hF && k < 300) begin
      @(negedge clk);
      k++;
    end
    check($sformatf("%s idle_timeout", name), rdy_v === 4'hF, 1'b1);
  endtask

  task automatic check_idle(input string name, input int cycles);
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        check($sformatf("%s idle tx[%0d] c%0d", name, i, k), tx_v[i], 1'b1);
        check($sformatf("%s idle ready[%0d] c%0d", name, i, k), rdy_v[i], 1'b1);
      end
    end
  endtask

  // Line bit b of instance i is exp_bits[i][b]; ready must rise in cycle exp_n*DIV+1.
  task automatic run_frame(input string name, input int l, input logic [8:0] d, input int pulse_at);
    int last = 0;
    wait_idle(name);
    @(negedge clk);
    len  = l;
    data = d;
    send = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 4; i++)
      if (exp_n[i] * DIV + 1 > last) last = exp_n[i] * DIV + 1;
    for (int j = 1; j <= last; j++) begin
      @(negedge clk);
      send = (pulse_at != 0 && j == pulse_at);
      if (j == 1) begin
        len  = 32'd1;
        data = 9'h000;
      end
      for (int i = 0; i < 4; i++) begin
        if (j <= exp_n[i] * DIV) begin
          check($sformatf("%s tx[%0d] c%0d", name, i, j), tx_v[i], exp_bits[i][(j-1)/DIV]);
          check($sformatf("%s busy[%0d] c%0d", name, i, j), rdy_v[i], 1'b0);
        end else if (j == exp_n[i] * DIV + 1) begin
          check($sformatf("%s ready[%0d] c%0d", name, i, j), rdy_v[i], 1'b1);
          check($sformatf("%s stop_hold[%0d] c%0d", name, i, j), tx_v[i], 1'b1);
        end
      end
    end
  endtask

  initial begin
    logic [15:0] pat;

    // Reset held 3 cycles with send asserted throughout: nothing may start.
    res  = 1'b1;
    send = 1'b1;
    len  = 32'd8;
    data = 9'h0A5;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        check($sformatf("reset tx[%0d] c%0d", i, k), tx_v[i], 1'b1);
        check($sformatf("reset ready[%0d] c%0d", i, k), rdy_v[i], 1'b1);
      end
    end
    res  = 1'b0;
    send = 1'b0;
    check_idle("post_reset", 8);

    // len=8, data=0A5 (four ones): even parity 0, odd parity 1; busy send pulse in cycle 20.
    exp_bits[0] = 16'({1'b1, 8'hA5, 1'b0});        exp_n[0] = 10;
    exp_bits[1] = 16'({1'b1, 1'b0, 8'hA5, 1'b0});  exp_n[1] = 11;
    exp_bits[2] = 16'({1'b1, 1'b1, 8'hA5, 1'b0});  exp_n[2] = 11;
    exp_bits[3] = 16'({2'b11, 8'hA5, 1'b0});       exp_n[3] = 11;
    run_frame("len8_a5", 8, 9'h0A5, 20);
    check_idle("after_pulse", 10);

    // len=9, all ones: even parity bit 1, odd 0; parity frames span 48 cycles.
    exp_bits[0] = 16'({1'b1, 9'h1FF, 1'b0});       exp_n[0] = 11;
    exp_bits[1] = 16'({1'b1, 1'b1, 9'h1FF, 1'b0}); exp_n[1] = 12;
    exp_bits[2] = 16'({1'b1, 1'b0, 9'h1FF, 1'b0}); exp_n[2] = 12;
    exp_bits[3] = 16'({2'b11, 9'h1FF, 1'b0});      exp_n[3] = 12;
    run_frame("len9_1ff", 9, 9'h1FF, 0);

    // len 0 and len 20 both clamp to 9 bits; bit 8 of 0A5 is 0, distinct from a stop bit.
    exp_bits[0] = 16'({1'b1, 9'h0A5, 1'b0});       exp_n[0] = 11;
    exp_bits[1] = 16'({1'b1, 1'b0, 9'h0A5, 1'b0}); exp_n[1] = 12;
    exp_bits[2] = 16'({1'b1, 1'b1, 9'h0A5, 1'b0}); exp_n[2] = 12;
    exp_bits[3] = 16'({2'b11, 9'h0A5, 1'b0});      exp_n[3] = 12;
    run_frame("len0", 0, 9'h0A5, 0);
    run_frame("len20", 20, 9'h0A5, 0);

    // len=4 of 155: bits 1,0,1,0 only; ignored upper bits hold three ones, so parity would flip.
    exp_bits[0] = 16'({1'b1, 4'h5, 1'b0});         exp_n[0] = 6;
    exp_bits[1] = 16'({1'b1, 1'b0, 4'h5, 1'b0});   exp_n[1] = 7;
    exp_bits[2] = 16'({1'b1, 1'b1, 4'h5, 1'b0});   exp_n[2] = 7;
    exp_bits[3] = 16'({2'b11, 4'h5, 1'b0});        exp_n[3] = 7;
    run_frame("len4_155", 4, 9'h155, 0);

    // send held: instance 0 restarts right after its one ready cycle, 41 cycles per frame.
    wait_idle("b2b");
    pat = 16'({1'b1, 8'hA5, 1'b0});
    @(negedge clk);
    len  = 32'd8;
    data = 9'h0A5;
    send = 1'b1;
    @(posedge clk);
    for (int j = 1; j <= 123; j++) begin
      @(negedge clk);
      if (j == 123) send = 1'b0;
      if ((j - 1) % 41 < 40) begin
        check($sformatf("b2b tx c%0d", j), tx_v[0], pat[((j-1) % 41) / DIV]);
        check($sformatf("b2b busy c%0d", j), rdy_v[0], 1'b0);
      end else begin
        check($sformatf("b2b ready c%0d", j), rdy_v[0], 1'b1);
        check($sformatf("b2b gap c%0d", j), tx_v[0], 1'b1);
      end
    end
    wait_idle("b2b_end");
    check_idle("b2b_end", 8);

    // Reset while data bit 1 (a zero) is on the line aborts every instance.
    @(negedge clk);
    len  = 32'd8;
    data = 9'h0A5;
    send = 1'b1;
    @(posedge clk);
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      send = 1'b0;
    end
    check("abort pre tx", tx_v[0], 1'b0);
    res = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("abort tx[%0d]", i), tx_v[i], 1'b1);
      check($sformatf("abort ready[%0d]", i), rdy_v[i], 1'b1);
    end
    check_idle("abort_idle", 12);

    // Fresh frame after abort; data bit 8 set but len=8 keeps it off the line.
    exp_bits[0] = 16'({1'b1, 8'h3C, 1'b0});        exp_n[0] = 10;
    exp_bits[1] = 16'({1'b1, 1'b0, 8'h3C, 1'b0});  exp_n[1] = 11;
    exp_bits[2] = 16'({1'b1, 1'b1, 8'h3C, 1'b0});  exp_n[2] = 11;
    exp_bits[3] = 16'({2'b11, 8'h3C, 1'b0});       exp_n[3] = 11;
    run_frame("after_abort", 8, 9'h13C, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
